// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline: register enables,
// bubble insertion, MDU handshake, stale imem tracking and perf counters.
//
// Ports:
//   clk, rst (sync, active-low)
//   imem_req/imem_resp, dmem_req/dmem_resp    memory handshakes
//   ex_br_taken, ex_is_muldiv, mdu_done       EX redirect / MDU status
//   ex_mem_read, ex_rd, id_rs1/2, id_uses_rs1/2  load-use detection
//   mdu_start                                 one-cycle MDU launch
//   load_* / flush_*                          pipeline register control
//   imem_discard                              drop stale imem response
//   stall_cnt, flush_cnt                      saturating perf counters
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_br_taken,
    input  logic             ex_is_muldiv,
    input  logic             mdu_done,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             mdu_start,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             imem_discard,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_e;

    typedef enum logic {
        IM_RUN,
        IM_DRAIN
    } imem_state_e;

    mdu_state_e       mdu_q, mdu_d;
    imem_state_e      imem_q, imem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic fetch_pend;
    logic dstall;
    logic mstall;
    logic lduse;
    logic istall;
    logic rs1_hit;
    logic rs2_hit;

    assign fetch_pend = imem_req & ~imem_resp;
    assign dstall     = dmem_req & ~dmem_resp;
    // The op only advances in the cycle the running MDU reports done.
    assign mstall     = ex_is_muldiv
                      & ~((mdu_q == MDU_BUSY) & mdu_done);
    assign rs1_hit    = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = id_uses_rs2 & (id_rs2 == ex_rd);
    assign lduse      = ex_mem_read & (ex_rd != 5'd0)
                      & (rs1_hit | rs2_hit);
    // While draining, PC already holds the redirect target, so
    // IF stays parked until the stale response has gone by.
    assign istall     = fetch_pend | (imem_q == IM_DRAIN);

    // One-hot priority selects, highest first.
    logic sel_d, sel_m, sel_r, sel_h, sel_n;

    assign sel_d = dstall;
    assign sel_m = ~sel_d & mstall;
    assign sel_r = ~sel_d & ~sel_m & ex_br_taken;
    assign sel_h = ~sel_d & ~sel_m & ~ex_br_taken
                 & (lduse | istall);
    assign sel_n = ~(sel_d | sel_m | sel_r | sel_h);

    always_comb begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        unique case (1'b1)
            sel_d: begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                load_id_ex  = 1'b0;
                load_ex_mem = 1'b0;
                load_mem_wb = 1'b0;
            end
            sel_m: begin
                load_pc      = 1'b0;
                load_if_id   = 1'b0;
                load_id_ex   = 1'b0;
                flush_ex_mem = 1'b1;
            end
            sel_r: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            sel_h: begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                flush_id_ex = 1'b1;
            end
            sel_n: begin
                load_pc = 1'b1;
            end
        endcase

        mdu_d     = mdu_q;
        mdu_start = 1'b0;
        unique case (mdu_q)
            MDU_IDLE: begin
                if (ex_is_muldiv & ~dstall) begin
                    mdu_d     = MDU_BUSY;
                    mdu_start = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done) begin
                    mdu_d = MDU_IDLE;
                end
            end
        endcase

        imem_d       = imem_q;
        imem_discard = 1'b0;
        unique case (imem_q)
            IM_RUN: begin
                if (sel_r & fetch_pend) begin
                    imem_d = IM_DRAIN;
                end
            end
            IM_DRAIN: begin
                imem_discard = imem_resp;
                if (imem_resp) begin
                    imem_d = IM_RUN;
                end
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (~load_pc & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (sel_r & ~(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end

        // Present a quiet, free-flowing pipeline while held in reset.
        if (!rst) begin
            load_pc      = 1'b1;
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
            mdu_start    = 1'b0;
            imem_discard = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mdu_q       <= MDU_IDLE;
            imem_q      <= IM_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            mdu_q       <= mdu_d;
            imem_q      <= imem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
